// File: rtl/div_8bits.sv
// rtl/div_8bits.sv - 8-bit sequential restoring divider with start/done handshake; optional SIGNED_DIV_EN for two's complement operands
module div_8bits (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] q,
  output logic [7:0] r,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero,
  output logic       ov_flag
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic [7:0] r_b;
  logic [7:0] r_rem;
  logic [7:0] r_dvd;
  logic [2:0] r_cnt;
  logic [7:0] r_q;
  logic [7:0] r_r;
  logic       r_dbz;
  logic       r_ov;

  logic [9:0] w_trial;
  logic       w_neg;
  logic [7:0] w_rem_next;
  logic [7:0] w_dvd_next;
  logic [7:0] w_a_mag;
  logic [7:0] w_b_mag;
  logic [7:0] w_q_fin;
  logic [7:0] w_r_fin;
  logic       w_ov_fin;
  logic       w_last;

`ifdef SIGNED_DIV_EN
  logic       r_sa;
  logic       r_sb;

  // Core runs on magnitudes; |-128| = 128 still fits the unsigned 8-bit core.
  always_comb begin
    w_a_mag  = a[7] ? (~a + 8'd1) : a;
    w_b_mag  = b[7] ? (~b + 8'd1) : b;
    w_q_fin  = (r_sa ^ r_sb) ? (~w_dvd_next + 8'd1) : w_dvd_next;
    w_r_fin  = r_sa ? (~w_rem_next + 8'd1) : w_rem_next;
    // Only -128 / -1 yields a positive quotient of 128, which is not representable.
    w_ov_fin = ~(r_sa ^ r_sb) & w_dvd_next[7];
  end

  // Operand signs captured at load, applied when the result is registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sa <= 1'b0;
      r_sb <= 1'b0;
    end else if (r_state == S_IDLE && start && b != 8'd0) begin
      r_sa <= a[7];
      r_sb <= b[7];
    end
  end
`else
  // Unsigned build: operands and results pass straight through.
  always_comb begin
    w_a_mag  = a;
    w_b_mag  = b;
    w_q_fin  = w_dvd_next;
    w_r_fin  = w_rem_next;
    w_ov_fin = 1'b0;
  end
`endif

  // One restoring step: shift {rem,dvd} left, trial-subtract the divisor, keep or restore.
  always_comb begin
    w_trial    = {1'b0, r_rem, r_dvd[7]} - {2'b00, r_b};
    w_neg      = w_trial[9];
    w_rem_next = w_neg ? {r_rem[6:0], r_dvd[7]} : w_trial[7:0];
    w_dvd_next = {r_dvd[6:0], ~w_neg};
    w_last     = (r_cnt == 3'd7);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: divide by zero skips the iterations entirely.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (b == 8'd0) ? S_FIN : S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_next = S_FIN;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: load on accepted start, iterate in CALC, register results entering FIN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_b   <= 8'd0;
      r_rem <= 8'd0;
      r_dvd <= 8'd0;
      r_cnt <= 3'd0;
      r_q   <= 8'd0;
      r_r   <= 8'd0;
      r_dbz <= 1'b0;
      r_ov  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (b == 8'd0) begin
              r_q   <= 8'hFF;
              r_r   <= a;
              r_dbz <= 1'b1;
              r_ov  <= 1'b0;
            end else begin
              r_b   <= w_b_mag;
              r_rem <= 8'd0;
              r_dvd <= w_a_mag;
              r_cnt <= 3'd0;
            end
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_dvd <= w_dvd_next;
          r_cnt <= r_cnt + 3'd1;
          if (w_last) begin
            r_q   <= w_q_fin;
            r_r   <= w_r_fin;
            r_dbz <= 1'b0;
            r_ov  <= w_ov_fin;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign q           = r_q;
  assign r           = r_r;
  assign div_by_zero = r_dbz;
  assign ov_flag     = r_ov;
  assign busy        = (r_state == S_CALC);
  assign done        = (r_state == S_FIN);

endmodule

// File: tb/tb_div_8bits.sv
// tb/tb_div_8bits.sv - directed self-checking bench for div_8bits
module tb_div_8bits;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] q;
  logic [7:0] r;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic       ov_flag;

  int n_checks = 0;
  int n_err    = 0;
  int lat;
  int nbusy;
  int ndone;

`ifdef SIGNED_DIV_EN
  localparam logic [7:0] Q200 = 8'hFA;  // -56 / 9 = -6
  localparam logic [7:0] R200 = 8'hFE;  // remainder -2
`else
  localparam logic [7:0] Q200 = 8'd22;
  localparam logic [7:0] R200 = 8'd2;
`endif

  div_8bits dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .q           (q),
    .r           (r),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .ov_flag     (ov_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one start pulse, then count cycles until done (bounded).
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, output int o_lat, output int o_busy);
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    tick();
    start  = 1'b0;
    a      = 8'h5A;
    b      = 8'hC3;
    o_lat  = 0;
    o_busy = 0;
    while (!done && o_lat < 20) begin
      if (busy) o_busy++;
      tick();
      o_lat++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'd0;
    b     = 8'd0;
    tick();
    tick();
    chk("rst_q", q, 0);
    chk("rst_r", r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_ov", ov_flag, 0);
    rst_n = 1'b1;
    tick();

    // 100 / 7
    do_op(8'd100, 8'd7, lat, nbusy);
    chk("t1_lat", lat, 8);
    chk("t1_busy_cycles", nbusy, 8);
    chk("t1_done_busy", busy, 0);
    chk("t1_q", q, 14);
    chk("t1_r", r, 2);
    chk("t1_dbz", div_by_zero, 0);
    tick();
    chk("t1_done_pulse", done, 0);
    tick();
    tick();
    chk("t1_hold_q", q, 14);
    chk("t1_hold_r", r, 2);

    // 255 / 1, then back-to-back 3 / 10 on the cycle after done
    do_op(8'd255, 8'd1, lat, nbusy);
    chk("t2_lat", lat, 8);
    chk("t2_q", q, 8'hFF);
    chk("t2_r", r, 0);
    tick();
    do_op(8'd3, 8'd10, lat, nbusy);
    chk("t2b_lat", lat, 8);
    chk("t2b_q", q, 0);
    chk("t2b_r", r, 3);

    // start during the done cycle is ignored
    a     = 8'd50;
    b     = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t2c_ignored_busy", busy, 0);
    chk("t2c_ignored_q", q, 0);

    // 5 / 0
    do_op(8'd5, 8'd0, lat, nbusy);
    chk("t3_lat", lat, 0);
    chk("t3_busy_cycles", nbusy, 0);
    chk("t3_busy", busy, 0);
    chk("t3_q", q, 8'hFF);
    chk("t3_r", r, 5);
    chk("t3_dbz", div_by_zero, 1);
    tick();
    chk("t3_done_pulse", done, 0);
    chk("t3_hold_dbz", div_by_zero, 1);

    // 200 / 9 with a second start while busy
    a     = 8'd200;
    b     = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    tick();
    lat++;
    tick();
    lat++;
    a     = 8'd1;
    b     = 8'd1;
    start = 1'b1;
    tick();
    lat++;
    start = 1'b0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    chk("t4_lat", lat, 8);
    chk("t4_q", q, Q200);
    chk("t4_r", r, R200);
    chk("t4_dbz", div_by_zero, 0);
    tick();
    tick();
    chk("t4_no_second_op", busy, 0);

    // reset mid-operation
    a     = 8'd200;
    b     = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_q", q, 0);
    chk("t5_r", r, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_dbz", div_by_zero, 0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) ndone++;
      tick();
    end
    chk("t5_no_done_after_abort", ndone, 0);
    do_op(8'd200, 8'd9, lat, nbusy);
    chk("t5b_lat", lat, 8);
    chk("t5b_q", q, Q200);
    chk("t5b_r", r, R200);

`ifdef SIGNED_DIV_EN
    tick();
    do_op(8'h9C, 8'd7, lat, nbusy);
    chk("s1_lat", lat, 8);
    chk("s1_q", q, 8'hF2);
    chk("s1_r", r, 8'hFE);
    chk("s1_ov", ov_flag, 0);
    tick();
    do_op(8'h80, 8'hFF, lat, nbusy);
    chk("s2_q", q, 8'h80);
    chk("s2_r", r, 0);
    chk("s2_ov", ov_flag, 1);
`else
    chk("u_ov_zero", ov_flag, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/div_8bits.md
Name: div_8bits

Overview:
- Sequential 8-bit restoring divider, the inverse arithmetic counterpart of the 8-bit add/sub datapath.
- Reuses one 8-bit subtract per cycle: compute a / b and a % b over 8 iterations.
- Start/done handshake; result registered and held until the next accepted start.
- Sits beside the add/sub unit in the arithmetic block; driven by the same controller.

Parameters:
- none (width fixed at 8; iteration count fixed at 8)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only when not busy
- a  input  8  dividend, captured on accepted start
- b  input  8  divisor, captured on accepted start
- q  output  8  quotient
- r  output  8  remainder
- busy  output  1  iteration in progress
- done  output  1  one-cycle pulse: q/r/div_by_zero/ov_flag valid
- div_by_zero  output  1  b was 0 for the finished operation
- ov_flag  output  1  signed overflow (SIGNED_DIV_EN only; else constant 0)

Behaviour:
- One clock, reset is synchronous and active-low: rst_n sampled low at a clk rising edge forces state IDLE.
  - Reset also clears q, r, busy, done, div_by_zero, ov_flag, the iteration counter and internal registers to 0.
  - Reset mid-operation aborts with no done pulse.
- States: IDLE, CALC, FIN.
- IDLE: start=1 at edge E0 latches a and b.
  - If b != 0: clear partial remainder, load dividend shift register, counter=0, go to CALC, busy=1.
  - If b == 0: go directly to FIN with q=8'hFF, r=a, div_by_zero=1; done is high in the cycle after E0.
- CALC: one restoring step per edge (E1..E8).
  - Shift {rem,dvd} left by 1.
  - Trial = rem_shifted - b, computed 9 bits wide.
  - If trial is non-negative: rem = trial and the quotient LSB is 1; else keep rem and the quotient LSB is 0.
  - Counter increments; after the 8th step (counter==7) go to FIN.
- FIN: q and r are registered at the E8 transition. done=1 and busy=0 for exactly one cycle, then return to IDLE.
- Latency: done high in the cycle following E8, i.e. 9 cycles after the start edge (1 cycle for divide by zero).
- q, r, div_by_zero and ov_flag hold their values after done until the next accepted start.
  - They are not cleared on start; they update only when FIN is entered.
- start while busy=1 is ignored, with no queuing.
- start while done=1 (FIN cycle) is ignored; it is accepted on the next cycle in IDLE.
- start held high continuously: a new operation begins every 10 cycles.
- a and b may change freely after the start edge.
- Unsigned results are always exact: q*b + r == a, r < b.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined: a, b, q and r are two's complement.
  - Magnitudes are taken at load; the core runs unsigned.
  - At FIN: q is negated if the operand signs differ; r takes the sign of the dividend (truncate toward zero).
  - a=8'h80, b=8'hFF: q=8'h80, r=0, ov_flag=1.
  - Divide by zero: q=8'hFF, r=a, div_by_zero=1.
  - Latency is unchanged.
- Undefined: fully unsigned; ov_flag is tied to 0.

Test Plan:
- Reset, then a=100, b=7, start pulse -> busy for 8 cycles; done on cycle 9; q=14, r=2, div_by_zero=0; values held after done.
- a=255, b=1 then a=3, b=10 -> q=255, r=0; then q=0, r=3; back-to-back start on the cycle after done is accepted.
- a=5, b=0 -> done 1 cycle after start; q=8'hFF, r=5, div_by_zero=1, busy never high.
- Start a=200, b=9, then start again at cycle 3 with a=1, b=1 -> second start ignored; q=22, r=2 at cycle 9.
- Start a=200, b=9, rst_n low at cycle 4 -> all outputs 0, state IDLE, no done pulse; a new start afterwards runs normally.
- SIGNED_DIV_EN: a=-100 (8'h9C), b=7 -> q=8'hF2, r=8'hFE; a=8'h80, b=8'hFF -> q=8'h80, ov_flag=1.
